// File: rtl/wfunc_ctrl.sv
// APB master sequencer for window_func: soft reset, table load from an AXI-Stream
// coefficient source, arm with status verify, and graceful stop with status polling.
module wfunc_ctrl #(
   parameter int FFT_SIZE = 8192,
   parameter int APB_AW   = $clog2(FFT_SIZE-1)+3,
   parameter int POLL_MAX = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_req,
   input  logic              stop_req,
   input  logic              coef_tvalid,
   output logic              coef_tready,
   input  logic              coef_tlast,
   input  logic [31:0]       coef_tdata,
   output logic              armed,
   output logic              busy,
   output logic              err,
   output logic [1:0]        err_code,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [APB_AW-1:0] paddr,
   output logic [31:0]       pwdata,
   input  logic [31:0]       prdata
);
   localparam int NW = $clog2(FFT_SIZE);
   localparam int PW = $clog2(POLL_MAX+1);
   localparam logic [APB_AW-1:0] CTRL_ADDR = APB_AW'(FFT_SIZE*4);
   localparam logic [APB_AW-1:0] STAT_ADDR = APB_AW'((FFT_SIZE+1)*4);
   localparam logic [31:0]       CMD_SRST  = 32'h0000_0001;
   localparam logic [31:0]       CMD_CHG   = 32'h0000_0100;
   localparam logic [NW-1:0]     N_LAST    = NW'(FFT_SIZE-1);
   localparam logic [PW-1:0]     POLL_LAST = PW'(POLL_MAX-1);

   typedef enum logic [3:0] {
      S_IDLE, S_SRST, S_LOAD, S_ARM, S_VFY, S_ARMED, S_STOP, S_SPOLL, S_FAIL
   } state_t;

   state_t              r_state;
   logic                r_psel;
   logic                r_penable;
   logic                r_pwrite;
   logic [APB_AW-1:0]   r_paddr;
   logic [31:0]         r_pwdata;
   logic [NW-1:0]       r_n;
   logic [PW-1:0]       r_poll;
   logic                r_load_end;
   logic                r_load_ok;
   logic                r_armed;
   logic                r_busy;
   logic                r_err;
   logic [1:0]          r_err_code;

   logic                w_req;
   logic                w_req_wr;
   logic [APB_AW-1:0]   w_req_addr;
   logic [31:0]         w_req_data;
   logic                w_access_end;
   logic                w_load_rdy;
   logic                w_load_go;
   logic [1:0]          w_stat;
   logic                w_unused_prdata;

   // Fixed-command transfer issued by each non-LOAD sequencing state
   always_comb begin
      w_req      = 1'b0;
      w_req_wr   = 1'b0;
      w_req_addr = '0;
      w_req_data = '0;
      case (r_state)
         S_SRST, S_FAIL: begin
            w_req = 1'b1; w_req_wr = 1'b1; w_req_addr = CTRL_ADDR; w_req_data = CMD_SRST;
         end
         S_ARM, S_STOP: begin
            w_req = 1'b1; w_req_wr = 1'b1; w_req_addr = CTRL_ADDR; w_req_data = CMD_CHG;
         end
         S_VFY, S_SPOLL: begin
            w_req = 1'b1; w_req_addr = STAT_ADDR;
         end
         default: ;
      endcase
   end

   assign w_access_end    = r_psel & r_penable;
   assign w_load_rdy      = (r_state == S_LOAD) & ~r_psel & ~r_load_end;
   assign w_load_go       = w_load_rdy & coef_tvalid;
   assign w_stat          = prdata[9:8];
   assign w_unused_prdata = ^{prdata[31:10], prdata[7:0]};

   // A coefficient handshake cycle doubles as the setup phase, giving 2 cycles per beat
   assign coef_tready = w_load_rdy;
   assign psel        = r_psel | w_load_go;
   assign penable     = r_penable;
   assign pwrite      = r_pwrite | w_load_go;
   assign paddr       = w_load_go ? APB_AW'({r_n, 2'b00}) : r_paddr;
   assign pwdata      = w_load_go ? coef_tdata : r_pwdata;
   assign armed       = r_armed;
   assign busy        = r_busy;
   assign err         = r_err;
   assign err_code    = r_err_code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_psel     <= 1'b0;
         r_penable  <= 1'b0;
         r_pwrite   <= 1'b0;
         r_paddr    <= '0;
         r_pwdata   <= '0;
         r_n        <= '0;
         r_poll     <= '0;
         r_load_end <= 1'b0;
         r_load_ok  <= 1'b0;
         r_armed    <= 1'b0;
         r_busy     <= 1'b0;
         r_err      <= 1'b0;
         r_err_code <= 2'b00;
      end else begin
         if (w_load_go) begin
            r_psel    <= 1'b1;
            r_penable <= 1'b1;
            r_pwrite  <= 1'b1;
            r_paddr   <= APB_AW'({r_n, 2'b00});
            r_pwdata  <= coef_tdata;
         end else if (w_req && !r_psel) begin
            r_psel   <= 1'b1;
            r_pwrite <= w_req_wr;
            r_paddr  <= w_req_addr;
            r_pwdata <= w_req_data;
         end else if (r_psel && !r_penable) begin
            r_penable <= 1'b1;
         end else if (w_access_end) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
         end

         case (r_state)
            S_IDLE: if (load_req) begin
               r_state    <= S_SRST;
               r_busy     <= 1'b1;
               r_err      <= 1'b0;
               r_err_code <= 2'b00;
            end
            S_SRST: if (w_access_end) begin
               r_state    <= S_LOAD;
               r_n        <= '0;
               r_load_end <= 1'b0;
               r_load_ok  <= 1'b0;
            end
            S_LOAD: begin
               // Any tlast or the final index ends the stream; only both together is valid
               if (w_load_go) begin
                  r_n <= r_n + 1'b1;
                  if (coef_tlast || (r_n == N_LAST)) begin
                     r_load_end <= 1'b1;
                     r_load_ok  <= coef_tlast && (r_n == N_LAST);
                  end
               end else if (w_access_end && r_load_end) begin
                  r_load_end <= 1'b0;
                  if (r_load_ok) begin
                     r_state <= S_ARM;
                  end else begin
                     r_state    <= S_IDLE;
                     r_busy     <= 1'b0;
                     r_err      <= 1'b1;
                     r_err_code <= 2'b01;
                  end
               end
            end
            S_ARM: if (w_access_end) begin
               r_state <= S_VFY;
               r_poll  <= '0;
            end
            S_VFY: if (w_access_end) begin
               if (w_stat == 2'b01 || w_stat == 2'b10) begin
                  r_state <= S_ARMED;
                  r_armed <= 1'b1;
                  r_busy  <= 1'b0;
               end else if (r_poll == POLL_LAST) begin
                  r_state <= S_FAIL;
               end else begin
                  r_poll <= r_poll + 1'b1;
               end
            end
            S_ARMED: if (stop_req) begin
               r_state <= S_STOP;
               r_armed <= 1'b0;
               r_busy  <= 1'b1;
            end
            S_STOP: if (w_access_end) begin
               r_state <= S_SPOLL;
               r_poll  <= '0;
            end
            S_SPOLL: if (w_access_end) begin
               if (w_stat == 2'b00) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else if (r_poll == POLL_LAST) begin
                  r_state <= S_FAIL;
               end else begin
                  r_poll <= r_poll + 1'b1;
               end
            end
            S_FAIL: if (w_access_end) begin
               r_state    <= S_IDLE;
               r_err      <= 1'b1;
               r_err_code <= 2'b10;
               r_busy     <= 1'b0;
               r_armed    <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
